alu_seq: RTL and testbench

Parametrised, registered, multi-cycle ALU for the DE10-Lite projects and the next generation of the combinational 8-bit ALU. It adds a start/done handshake, a full double-width product from an iterative shift-add multiplier, wider operand support, extra logic ops and an optional restoring divider. It sits between the operand registers and the display/compare logic of the Combination Lock datapath, and is reusable by any project that needs registered arithmetic with condition codes.

---
 rtl/alu_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with start/done handshake.
// Optional restoring divider on op 111 when ALU_SEQ_DIV_EN is defined.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       aluOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] RH,
  output logic [5:0]       CC
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_X7  = 3'b111;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] s_r;
  logic [5:0]       s_cc;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;
  logic [5:0]       it_cc;
  logic             is_mul;
  logic             iter_op;
  logic             accept;

  assign busy   = (state == S_ITER);
  assign done   = (state == S_DONE);
  assign accept = start && (state != S_ITER);
  assign sum    = {1'b0, A} + {1'b0, B};
  assign diff   = A - B;
  assign is_mul = (op_q == OP_MUL);

`ifdef ALU_SEQ_DIV_EN
  assign iter_op = (aluOp == OP_MUL) || (aluOp == OP_X7);
`else
  assign iter_op = (aluOp == OP_MUL);
`endif

  // Single-cycle result and flags from the operands being accepted
  always_comb begin
    s_r  = '0;
    s_cc = '0;
    unique case (aluOp)
      OP_ADD: begin
        s_r     = sum[WIDTH-1:0];
        s_cc[3] = sum[WIDTH];
        s_cc[5] = (A[WIDTH-1] == B[WIDTH-1]) &&
                  (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        s_r     = diff;
        s_cc[4] = (A[WIDTH-1] != B[WIDTH-1]) &&
                  (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: s_r = A & B;
      OP_OR:  s_r = A | B;
      OP_XOR: s_r = A ^ B;
      OP_SHL: begin
        s_r     = {A[WIDTH-2:0], 1'b0};
        s_cc[3] = A[WIDTH-1];
      end
      default: ;
    endcase
    if (aluOp != OP_X7) begin
      s_cc[2] = (A < B);
      s_cc[1] = (s_r == '0);
      s_cc[0] = s_r[WIDTH-1];
    end
  end

  // One shift-add or restoring-subtract step on {hi,lo}
  always_comb begin
    logic [WIDTH:0] ms;
    ms    = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    hi_nx = ms[WIDTH:1];
    lo_nx = {ms[0], lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    if (!is_mul) begin
      logic [WIDTH:0] rs;
      logic           ge;
      rs    = {hi, lo[WIDTH-1]};
      ge    = (rs >= {1'b0, b_q});
      hi_nx = ge ? (rs[WIDTH-1:0] - b_q) : rs[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], ge};
    end
`endif
  end

  // Flags for the final iterative step, from latched operands
  always_comb begin
    it_cc    = '0;
    it_cc[3] = is_mul ? (hi_nx != '0) : (b_q == '0);
    it_cc[2] = (a_q < b_q);
    it_cc[1] = is_mul ? ({hi_nx, lo_nx} == '0) : (lo_nx == '0);
    it_cc[0] = lo_nx[WIDTH-1];
  end

  // Control FSM, operand latches and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      R     <= '0;
      RH    <= '0;
      CC    <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= aluOp;
            if (iter_op) begin
              state <= S_ITER;
              cnt   <= CW'(WIDTH);
              hi    <= '0;
              lo    <= A;
            end else begin
              state <= S_DONE;
              R     <= s_r;
              RH    <= '0;
              CC    <= s_cc;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_ITER: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= S_DONE;
            R     <= lo_nx;
            RH    <= hi_nx;
            CC    <= it_cc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq, scoreboard-checked.
// Expected {R,RH,CC} are queued at issue and popped on each done.
module tb_alu_seq;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] rh;
    logic [5:0]   cc;
  } exp_t;

  logic         clk = 0;
  logic         reset = 1;
  logic         start = 0;
  logic [2:0]   aluOp = 0;
  logic [W-1:0] A = 0;
  logic [W-1:0] B = 0;
  logic         busy;
  logic         done;
  logic [W-1:0] R;
  logic [W-1:0] RH;
  logic [5:0]   CC;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .aluOp(aluOp), .A(A), .B(B),
    .busy(busy), .done(done),
    .R(R), .RH(RH), .CC(CC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               name, act, req);
    end
  endtask

  // Monitor: pop and compare on every done cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (busy && done)
        chk("busy_and_done", 1, 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("R", R, e.r);
          chk("RH", RH, e.rh);
          chk("CC", CC, e.cc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic push,
                       input logic [W-1:0] er,
                       input logic [W-1:0] erh,
                       input logic [5:0] ecc);
    exp_t e;
    e = '{r: er, rh: erh, cc: ecc};
    if (push) exp_q.push_back(e);
    aluOp = op;
    A = a;
    B = b;
    start = 1;
    step();
    start = 0;
  endtask

  // Wait for done; n0 is the cycle index already reached
  task automatic wait_done(input string name,
                           input int lat,
                           input int n0);
    int n;
    n = n0;
    if (lat > 1 && n0 == 1)
      chk({name, "_busy"}, busy, 1);
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk({name, "_lat"}, n, lat);
    step();
    chk({name, "_pulse"}, done, 0);
  endtask

  initial begin
    int seen;
    step();
    step();
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", {R, RH, CC}, 0);

    issue(3'b000, 8'hF0, 8'h20, 1, 8'h10, 8'h00, 6'h08);
    wait_done("add_carry", 1, 1);
    issue(3'b000, 8'h7F, 8'h01, 1, 8'h80, 8'h00, 6'h21);
    wait_done("add_ovf", 1, 1);
    issue(3'b001, 8'h80, 8'h01, 1, 8'h7F, 8'h00, 6'h10);
    wait_done("sub_ovf", 1, 1);
    issue(3'b001, 8'h05, 8'h05, 1, 8'h00, 8'h00, 6'h02);
    wait_done("sub_zero", 1, 1);
    issue(3'b100, 8'h12, 8'h40, 1, 8'h52, 8'h00, 6'h04);
    wait_done("or", 1, 1);

    issue(3'b010, 8'h0F, 8'h03, 1, 8'h2D, 8'h00, 6'h00);
    wait_done("mul_small", 9, 1);
    issue(3'b010, 8'h00, 8'h05, 1, 8'h00, 8'h00, 6'h06);
    wait_done("mul_zero", 9, 1);
    issue(3'b010, 8'h10, 8'h10, 1, 8'h00, 8'h01, 6'h08);
    wait_done("mul_hi_only", 9, 1);

    issue(3'b010, 8'hFF, 8'hFF, 1, 8'h01, 8'hFE, 6'h08);
    step();
    start = 1;
    aluOp = 3'b000;
    A = 8'h01;
    B = 8'h01;
    step();
    start = 0;
    wait_done("mul_ff", 9, 3);

    issue(3'b010, 8'h10, 8'h10, 0, 8'h00, 8'h00, 6'h00);
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_out", {done, R, RH, CC}, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen = 1;
      step();
    end
    chk("abort_no_done", seen, 0);

    issue(3'b011, 8'hAA, 8'h0F, 1, 8'h0A, 8'h00, 6'h00);
    wait_done("and", 1, 1);

    exp_q.push_back('{r: 8'hC3, rh: 8'h00, cc: 6'h05});
    exp_q.push_back('{r: 8'h02, rh: 8'h00, cc: 6'h08});
    aluOp = 3'b101;
    A = 8'h3C;
    B = 8'hFF;
    start = 1;
    step();
    chk("b2b_first", done, 1);
    aluOp = 3'b110;
    A = 8'h81;
    B = 8'h00;
    step();
    start = 0;
    chk("b2b_second", done, 1);
    step();
    chk("b2b_end", done, 0);

`ifdef ALU_SEQ_DIV_EN
    issue(3'b111, 8'd200, 8'd7, 1, 8'd28, 8'd4, 6'h00);
    wait_done("div", 9, 1);
    issue(3'b111, 8'd9, 8'd0, 1, 8'hFF, 8'd9, 6'h09);
    wait_done("div_zero", 9, 1);
`else
    issue(3'b111, 8'h55, 8'h66, 1, 8'h00, 8'h00, 6'h00);
    wait_done("reserved", 1, 1);
`endif

    step();
    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
